intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Parametrised N-source interrupt controller. It replaces the single-line interrupt latch in front of the MCU's interrupt input.
- Synchronises and latches up to 8 interrupt sources, with per-source mask and edge/level mode.
- Arbitrates by fixed priority and drives the MCU interrupt request. Exposes the winning source ID.
- Provides mask, pending and in-service registers on the MCU I/O port bus.

Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 1..8.
- BASE_ID, 8'hF0, port ID of register 0. Registers occupy BASE_ID..BASE_ID+2.
- EDGE_MODE, 8'hFF, per-source mode bit: 1 = rising-edge latched, 0 = level-sensitive.
- IDW, 3, width of INT_ID.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- IRQ_IN  in  NUM_SRC  asynchronous interrupt sources.
- PORT_ID  in  8  MCU port address.
- OUT_PORT  in  8  MCU write data.
- IO_STRB  in  1  MCU write strobe; one cycle per OUTPUT instruction.
- INT_ACK  in  1  one-cycle pulse from the control unit when it enters the interrupt cycle.
- INT_DONE  in  1  one-cycle pulse from the control unit on RETIE/RETID.
- INT_R  out  1  registered interrupt request to the control unit.
- INT_ID  out  IDW  ID of the source being serviced; valid from ACK until DONE.
- RD_DATA  out  8  combinational read data for the IN_PORT mux.
- RD_HIT  out  1  high when PORT_ID addresses one of this block's registers.

Behaviour:
- Reset (synchronous, RESET=1 at an edge): all of the following clear to 0 and state goes to IDLE:
  - sync flops, prev flops, MASK, PENDING, INT_ID, INT_R.
- Reset overrides every other input in the same cycle. Reset mid-SERVICE abandons the service with no residual pending.
- Input path:
  - Each IRQ_IN bit passes through a 2-flop synchroniser (s1, s2), then a prev flop (p).
- Edge source (EDGE_MODE[i]=1):
  - PENDING[i] is set on the edge where s2=1 and p=0.
  - Raw IRQ high first sampled at edge E0 gives PENDING[i]=1 after edge E2.
  - Cleared by a write-1 to the PENDING register, or by INT_ACK selecting source i.
  - Set beats clear in the same cycle.
- Level source (EDGE_MODE[i]=0):
  - PENDING[i] follows s2 each cycle.
  - Write-1-clear and ACK have no effect on it.
- Bits at index ≥ NUM_SRC read 0 and ignore writes.
- Registers (write when IO_STRB=1 and PORT_ID matches):
  - BASE_ID+0: MASK, RW; 1 = enabled.
  - BASE_ID+1: PENDING; read; write-1-to-clear.
  - BASE_ID+2: {INSVC, 4'b0, INT_ID}, read-only; INSVC=1 in SERVICE. Unused INT_ID bits zero-fill.
  - RD_HIT=1 and RD_DATA = selected register when PORT_ID is in range. Otherwise RD_HIT=0 and RD_DATA=0.
- Arbitration:
  - eligible = PENDING & MASK.
  - Winner = lowest set index; index 0 is highest priority.
- FSM:
  - IDLE: if eligible≠0 at an edge, go to REQ and INT_R=1 after that edge. Earliest INT_R is the edge after PENDING sets.
  - REQ:
    - INT_R held at 1.
    - If eligible becomes 0 (masked or cleared): back to IDLE, INT_R=0 at the same edge.
    - On INT_ACK: INT_ID ← current winner; clear that PENDING bit (edge mode); go to SERVICE with INT_R=0.
    - ACK and eligible=0 in the same cycle: ACK wins only if eligible was nonzero at that edge, else go to IDLE.
  - SERVICE:
    - INT_R=0; no nesting. New pendings accumulate.
    - On INT_DONE go to IDLE. If eligible≠0 then, REQ follows on the next edge.
- Stray strobes:
  - INT_ACK outside REQ is ignored.
  - INT_DONE outside SERVICE is ignored.
  - ACK and DONE together: handled per the current state only.
- Register writes and ACK in the same cycle: PENDING next = (old & ~w1c & ~ackclr) | newset.

Test Plan:
- Reset, then pulse IRQ_IN[3] high for 1 cycle with MASK=0 → PENDING=8'h08, INT_R stays 0. Write MASK=8'h08 → INT_R=1 within 2 edges.
- MASK=8'hFF, raise IRQ_IN[5] and IRQ_IN[2] in the same cycle, then ACK → INT_ID=2, PENDING=8'h20, INT_R=0. DONE → INT_R=1 again. Next ACK → INT_ID=5.
- In REQ for source 4, write MASK=0 → INT_R falls the following edge, FSM in IDLE, PENDING[4] still 1.
- Level source 1 (EDGE_MODE=8'hFD) held high; ACK then DONE → INT_R reasserts; write-1-clear PENDING[1] has no effect until IRQ_IN[1] drops.
- Read port BASE_ID+2 during SERVICE of source 6 → RD_DATA=8'h86, RD_HIT=1. Read port 8'h00 → RD_HIT=0, RD_DATA=0.
- Assert RESET in SERVICE with PENDING=8'h0F → next edge: all registers 0, INT_R=0, state IDLE. Stray INT_DONE afterward has no effect.

Source files
------------

// File: rtl/intr_ctrl.sv
// N-source interrupt controller: synchronised edge/level latching, fixed-priority
// arbitration, REQ/ACK/DONE handshake with the MCU and port-mapped mask/pending/status.
module intr_ctrl #(
  parameter int          NUM_SRC   = 8,
  parameter logic [7:0]  BASE_ID   = 8'hF0,
  parameter logic [7:0]  EDGE_MODE = 8'hFF,
  parameter int          IDW       = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  input  logic               IO_STRB,
  input  logic               INT_ACK,
  input  logic               INT_DONE,
  output logic               INT_R,
  output logic [IDW-1:0]     INT_ID,
  output logic [7:0]         RD_DATA,
  output logic               RD_HIT
);

  // Register state is kept 8 bits wide; bits at or above NUM_SRC are forced to 0.
  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);
  localparam logic [7:0] EDGE_M   = EDGE_MODE & SRC_MASK;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  logic [NUM_SRC-1:0] s1_q, s2_q, p_q;
  logic [7:0]         mask_q, mask_d, pend_q, pend_d;
  state_t             state_q;
  logic               int_r_q;
  logic [IDW-1:0]     int_id_q;

  logic [7:0]     elig, s2_w, rise_w, ack_clr, w1c, off;
  logic [IDW-1:0] win;
  logic           ack_take, wr_mask, wr_pend;

  always_comb begin
    s2_w   = 8'(s2_q);
    rise_w = 8'(s2_q & ~p_q);
    elig   = pend_q & mask_q;
    win    = '0;
    // Scan high to low so the lowest eligible index wins.
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (elig[i]) win = IDW'(i);
    ack_take = (state_q == REQ) && INT_ACK && (elig != 8'd0);
    ack_clr  = ack_take ? (8'd1 << win) : 8'd0;
    off      = PORT_ID - BASE_ID;
    wr_mask  = IO_STRB && (off == 8'd0);
    wr_pend  = IO_STRB && (off == 8'd1);
    w1c      = wr_pend ? OUT_PORT : 8'd0;
    mask_d   = wr_mask ? (OUT_PORT & SRC_MASK) : mask_q;
    // Edge bits: a new rising edge beats any clear in the same cycle.
    pend_d   = ((((pend_q & ~w1c & ~ack_clr) | rise_w) & EDGE_M) |
                (s2_w & ~EDGE_M)) & SRC_MASK;
  end

  always_comb begin
    RD_HIT  = (off < 8'd3);
    RD_DATA = 8'd0;
    case (off)
      8'd0:    RD_DATA = mask_q;
      8'd1:    RD_DATA = pend_q;
      8'd2:    RD_DATA = {state_q == SERVICE, 4'b0000, 3'(int_id_q)};
      default: RD_DATA = 8'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_q   <= '0;
      s2_q   <= '0;
      p_q    <= '0;
      mask_q <= 8'd0;
      pend_q <= 8'd0;
    end else begin
      s1_q   <= IRQ_IN;
      s2_q   <= s1_q;
      p_q    <= s2_q;
      mask_q <= mask_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      int_r_q  <= 1'b0;
      int_id_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (elig != 8'd0) begin
            state_q <= REQ;
            int_r_q <= 1'b1;
          end
        end
        REQ: begin
          if (elig == 8'd0) begin
            state_q <= IDLE;
            int_r_q <= 1'b0;
          end else if (INT_ACK) begin
            state_q  <= SERVICE;
            int_r_q  <= 1'b0;
            int_id_q <= win;
          end
        end
        SERVICE: begin
          int_r_q <= 1'b0;
          if (INT_DONE) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          int_r_q <= 1'b0;
        end
      endcase
    end
  end

  assign INT_R  = int_r_q;
  assign INT_ID = int_id_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios plus a randomized run against a
// sample-history reference model of the controller.
module tb_intr_ctrl;
  localparam logic [7:0] BASE = 8'hF0;
  localparam logic [7:0] EDGE = 8'hFD;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] IRQ_IN = 8'd0, PORT_ID = 8'd0, OUT_PORT = 8'd0;
  logic       IO_STRB = 1'b0, INT_ACK = 1'b0, INT_DONE = 1'b0;
  logic       INT_R, RD_HIT;
  logic [2:0] INT_ID;
  logic [7:0] RD_DATA;

  int total = 0;
  int bad   = 0;

  intr_ctrl #(.NUM_SRC(8), .BASE_ID(BASE), .EDGE_MODE(EDGE), .IDW(3)) dut (
    .CLK(CLK), .RESET(RESET), .IRQ_IN(IRQ_IN), .PORT_ID(PORT_ID),
    .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .INT_ACK(INT_ACK),
    .INT_DONE(INT_DONE), .INT_R(INT_R), .INT_ID(INT_ID),
    .RD_DATA(RD_DATA), .RD_HIT(RD_HIT)
  );

  always #5 CLK = ~CLK;

  // Reference model: raw samples of IRQ_IN from the last three edges
  // (r1 = one edge ago ... r3 = three edges ago) stand in for the input path.
  typedef enum {M_IDLE, M_REQ, M_SVC} mst_t;
  mst_t       m_st = M_IDLE;
  logic [7:0] m_mask = 8'd0, m_pend = 8'd0, r1 = 8'd0, r2 = 8'd0, r3 = 8'd0;
  logic       m_int_r = 1'b0;
  logic [2:0] m_id = 3'd0;

  task automatic model_update();
    logic [7:0] elig, nxt;
    int win;
    bit took, clr;
    if (RESET) begin
      m_st = M_IDLE; m_mask = 8'd0; m_pend = 8'd0; m_int_r = 1'b0; m_id = 3'd0;
      r1 = 8'd0; r2 = 8'd0; r3 = 8'd0;
    end else begin
      elig = m_pend & m_mask;
      win = -1;
      for (int i = 0; i < 8; i++) if (elig[i] && win < 0) win = i;
      took = (m_st == M_REQ) && INT_ACK && (win >= 0);
      for (int i = 0; i < 8; i++) begin
        if (EDGE[i]) begin
          clr = (IO_STRB && PORT_ID == BASE + 8'd1 && OUT_PORT[i]) || (took && win == i);
          if (r2[i] && !r3[i]) nxt[i] = 1'b1;
          else if (clr)        nxt[i] = 1'b0;
          else                 nxt[i] = m_pend[i];
        end else begin
          nxt[i] = r2[i];
        end
      end
      if (IO_STRB && PORT_ID == BASE) m_mask = OUT_PORT;
      case (m_st)
        M_IDLE: if (win >= 0) begin m_st = M_REQ; m_int_r = 1'b1; end
        M_REQ: begin
          if (win < 0) begin m_st = M_IDLE; m_int_r = 1'b0; end
          else if (took) begin m_st = M_SVC; m_int_r = 1'b0; m_id = 3'(win); end
        end
        default: if (INT_DONE) m_st = M_IDLE;
      endcase
      m_pend = nxt;
      r3 = r2; r2 = r1; r1 = IRQ_IN;
    end
  endtask

  function automatic logic [7:0] m_reg(int k);
    case (k)
      0:       return m_mask;
      1:       return m_pend;
      default: return {m_st == M_SVC, 4'b0000, m_id};
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic wr(input logic [7:0] port, input logic [7:0] data);
    IO_STRB = 1'b1; PORT_ID = port; OUT_PORT = data;
    tick();
    IO_STRB = 1'b0;
  endtask

  task automatic rd(input logic [7:0] port);
    PORT_ID = port;
    #1;
  endtask

  task automatic pulse_ack();
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
  endtask

  task automatic pulse_done();
    INT_DONE = 1'b1; tick(); INT_DONE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; tick(); tick(); RESET = 1'b0;
    total++; if (INT_R !== 1'b0) begin bad++; $display("FAIL reset_int_r: got %b want 0", INT_R); end
    total++; if (INT_ID !== 3'd0) begin bad++; $display("FAIL reset_int_id: got %0d want 0", INT_ID); end
    for (int k = 0; k < 3; k++) begin
      rd(BASE + 8'(k));
      total++;
      if (RD_DATA !== 8'h00 || RD_HIT !== 1'b1) begin
        bad++; $display("FAIL reset_reg%0d: got %h/%b want 00/1", k, RD_DATA, RD_HIT);
      end
    end
  endtask

  task automatic test_mask_pend();
    IRQ_IN = 8'h08; tick(); IRQ_IN = 8'h00;
    tick(); tick(); tick();
    rd(BASE + 8'd1);
    total++; if (RD_DATA !== 8'h08) begin bad++; $display("FAIL masked_pend: got %h want 08", RD_DATA); end
    total++; if (INT_R !== 1'b0) begin bad++; $display("FAIL masked_int_r: got %b want 0", INT_R); end
    wr(BASE, 8'h08);
    for (int k = 0; k < 2 && INT_R !== 1'b1; k++) tick();
    total++; if (INT_R !== 1'b1) begin bad++; $display("FAIL unmask_req: got %b want 1", INT_R); end
    pulse_ack();
    total++; if (INT_ID !== 3'd3) begin bad++; $display("FAIL ack_id3: got %0d want 3", INT_ID); end
    pulse_done();
  endtask

  task automatic test_priority();
    wr(BASE, 8'hFF);
    IRQ_IN = 8'h24; tick(); IRQ_IN = 8'h00;
    tick(); tick(); tick();
    total++; if (INT_R !== 1'b1) begin bad++; $display("FAIL prio_req: got %b want 1", INT_R); end
    pulse_ack();
    rd(BASE + 8'd1);
    total++; if (INT_ID !== 3'd2) begin bad++; $display("FAIL prio_first_id: got %0d want 2", INT_ID); end
    total++; if (RD_DATA !== 8'h20) begin bad++; $display("FAIL prio_pend: got %h want 20", RD_DATA); end
    total++; if (INT_R !== 1'b0) begin bad++; $display("FAIL prio_svc_int_r: got %b want 0", INT_R); end
    pulse_done();
    for (int k = 0; k < 2 && INT_R !== 1'b1; k++) tick();
    total++; if (INT_R !== 1'b1) begin bad++; $display("FAIL prio_rereq: got %b want 1", INT_R); end
    pulse_ack();
    rd(BASE + 8'd1);
    total++; if (INT_ID !== 3'd5) begin bad++; $display("FAIL prio_second_id: got %0d want 5", INT_ID); end
    total++; if (RD_DATA !== 8'h00) begin bad++; $display("FAIL prio_pend_empty: got %h want 00", RD_DATA); end
    pulse_done();
  endtask

  task automatic test_unmask_in_req();
    IRQ_IN = 8'h10; tick(); IRQ_IN = 8'h00;
    for (int k = 0; k < 5 && INT_R !== 1'b1; k++) tick();
    total++; if (INT_R !== 1'b1) begin bad++; $display("FAIL req4: got %b want 1", INT_R); end
    wr(BASE, 8'h00);
    total++; if (INT_R !== 1'b1) begin bad++; $display("FAIL mask_edge_int_r: got %b want 1", INT_R); end
    tick();
    total++; if (INT_R !== 1'b0) begin bad++; $display("FAIL mask_drop_int_r: got %b want 0", INT_R); end
    rd(BASE + 8'd1);
    total++; if (RD_DATA !== 8'h10) begin bad++; $display("FAIL mask_keep_pend: got %h want 10", RD_DATA); end
    rd(BASE + 8'd2);
    total++; if (RD_DATA[7] !== 1'b0) begin bad++; $display("FAIL mask_insvc: got %b want 0", RD_DATA[7]); end
    wr(BASE + 8'd1, 8'hFF);
    rd(BASE + 8'd1);
    total++; if (RD_DATA !== 8'h00) begin bad++; $display("FAIL w1c_all: got %h want 00", RD_DATA); end
  endtask

  task automatic test_level();
    wr(BASE, 8'h02);
    IRQ_IN = 8'h02;
    for (int k = 0; k < 6 && INT_R !== 1'b1; k++) tick();
    total++; if (INT_R !== 1'b1) begin bad++; $display("FAIL lvl_req: got %b want 1", INT_R); end
    pulse_ack();
    rd(BASE + 8'd1);
    total++; if (INT_ID !== 3'd1) begin bad++; $display("FAIL lvl_id: got %0d want 1", INT_ID); end
    total++; if (RD_DATA !== 8'h02) begin bad++; $display("FAIL lvl_ack_pend: got %h want 02", RD_DATA); end
    pulse_done();
    for (int k = 0; k < 2 && INT_R !== 1'b1; k++) tick();
    total++; if (INT_R !== 1'b1) begin bad++; $display("FAIL lvl_rereq: got %b want 1", INT_R); end
    wr(BASE + 8'd1, 8'h02);
    rd(BASE + 8'd1);
    total++; if (RD_DATA !== 8'h02) begin bad++; $display("FAIL lvl_w1c_ignored: got %h want 02", RD_DATA); end
    IRQ_IN = 8'h00;
    for (int k = 0; k < 5; k++) tick();
    rd(BASE + 8'd1);
    total++; if (RD_DATA !== 8'h00) begin bad++; $display("FAIL lvl_drop_pend: got %h want 00", RD_DATA); end
    total++; if (INT_R !== 1'b0) begin bad++; $display("FAIL lvl_drop_int_r: got %b want 0", INT_R); end
  endtask

  task automatic test_read_port();
    wr(BASE, 8'hFF);
    IRQ_IN = 8'h40; tick(); IRQ_IN = 8'h00;
    for (int k = 0; k < 5 && INT_R !== 1'b1; k++) tick();
    pulse_ack();
    rd(BASE + 8'd2);
    total++; if (RD_DATA !== 8'h86 || RD_HIT !== 1'b1) begin bad++; $display("FAIL status_svc6: got %h/%b want 86/1", RD_DATA, RD_HIT); end
    rd(8'h00);
    total++; if (RD_DATA !== 8'h00 || RD_HIT !== 1'b0) begin bad++; $display("FAIL miss_00: got %h/%b want 00/0", RD_DATA, RD_HIT); end
    rd(BASE + 8'd3);
    total++; if (RD_DATA !== 8'h00 || RD_HIT !== 1'b0) begin bad++; $display("FAIL miss_above: got %h/%b want 00/0", RD_DATA, RD_HIT); end
    rd(BASE - 8'd1);
    total++; if (RD_DATA !== 8'h00 || RD_HIT !== 1'b0) begin bad++; $display("FAIL miss_below: got %h/%b want 00/0", RD_DATA, RD_HIT); end
  endtask

  task automatic test_reset_in_service();
    IRQ_IN = 8'h0F;
    for (int k = 0; k < 4; k++) tick();
    rd(BASE + 8'd1);
    total++; if (RD_DATA !== 8'h0F) begin bad++; $display("FAIL svc_pend: got %h want 0F", RD_DATA); end
    total++; if (INT_R !== 1'b0) begin bad++; $display("FAIL svc_no_nest: got %b want 0", INT_R); end
    RESET = 1'b1; IRQ_IN = 8'h00; tick(); RESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rd(BASE + 8'(k));
      total++; if (RD_DATA !== 8'h00) begin bad++; $display("FAIL rst_svc_reg%0d: got %h want 00", k, RD_DATA); end
    end
    total++; if (INT_R !== 1'b0 || INT_ID !== 3'd0) begin bad++; $display("FAIL rst_svc_out: got %b/%0d want 0/0", INT_R, INT_ID); end
    pulse_done();
    tick(); tick();
    rd(BASE + 8'd2);
    total++; if (RD_DATA !== 8'h00 || INT_R !== 1'b0) begin bad++; $display("FAIL stray_done: got %h/%b want 00/0", RD_DATA, INT_R); end
    rd(BASE + 8'd1);
    total++; if (RD_DATA !== 8'h00) begin bad++; $display("FAIL stray_done_pend: got %h want 00", RD_DATA); end
  endtask

  task automatic test_random();
    logic [7:0] exp_v;
    int k;
    RESET = 1'b1; tick(); RESET = 1'b0;
    for (int n = 0; n < 500; n++) begin
      IRQ_IN  = IRQ_IN ^ 8'($urandom & $urandom & $urandom);
      IO_STRB = ($urandom_range(0, 3) == 0);
      PORT_ID = BASE + 8'($urandom_range(0, 3));
      OUT_PORT = 8'($urandom);
      INT_ACK  = ($urandom_range(0, 2) == 0);
      INT_DONE = ($urandom_range(0, 3) == 0);
      tick();
      IO_STRB = 1'b0; INT_ACK = 1'b0; INT_DONE = 1'b0;
      total++; if (INT_R !== m_int_r) begin bad++; $display("FAIL rnd_int_r @%0d: got %b want %b", n, INT_R, m_int_r); end
      total++; if (INT_ID !== m_id) begin bad++; $display("FAIL rnd_int_id @%0d: got %0d want %0d", n, INT_ID, m_id); end
      k = n % 3;
      exp_v = m_reg(k);
      rd(BASE + 8'(k));
      total++; if (RD_DATA !== exp_v) begin bad++; $display("FAIL rnd_reg%0d @%0d: got %h want %h", k, n, RD_DATA, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_mask_pend();
    test_priority();
    test_unmask_in_req();
    test_level();
    test_read_port();
    test_reset_in_service();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
